// File: rtl/spiflash_responder.sv
// rtl/spiflash_responder.sv - SPI flash target (mode 0) serving READ / JEDEC-ID from a sync-read memory
//
// Ports:
//   core_clk, core_rst_n        block clock, asynchronous active-low reset
//   spiflash_cs_n/clk/mosi      SPI pins from the SoC, asynchronous to core_clk
//   spiflash_miso, _oe          serial data out and pad drive enable (miso is 0 while oe is 0)
//   mem_en, mem_addr            one-cycle read strobe and address
//   mem_rdata                   read data, valid one cycle after mem_en
// Build option: define SPIFLASH_RESP_FASTREAD_EN to support FAST READ (0x0B, 8 dummy clocks).
module spiflash_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
  input  logic                  spiflash_cs_n,
  input  logic                  spiflash_clk,
  input  logic                  spiflash_mosi,
  output logic                  spiflash_miso,
  output logic                  spiflash_miso_oe,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata
);

  // The receive shifter holds one bit fewer than the address; the incoming
  // MOSI bit completes it combinationally on the final rise.
  localparam int unsigned SR_W = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ID,
    S_IGNORE
`ifdef SPIFLASH_RESP_FASTREAD_EN
    , S_DUMMY
`endif
  } state_e;

  logic [1:0]            cs_sync_q, cs_sync_d, clk_sync_q, clk_sync_d, mosi_sync_q, mosi_sync_d;
  logic                  cs_prev_q, cs_prev_d, clk_prev_q, clk_prev_d;
  state_e                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]       rx_sr_q, rx_sr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic                  mem_en_q, mem_en_d, fetch_pend_q, fetch_pend_d;
  logic [7:0]            prefetch_q, prefetch_d, tx_sr_q, tx_sr_d;
  logic [2:0]            tx_cnt_q, tx_cnt_d;
  logic [1:0]            id_idx_q, id_idx_d;
  logic                  miso_q, miso_d, miso_oe_q, miso_oe_d;
`ifdef SPIFLASH_RESP_FASTREAD_EN
  logic [7:0]            cmd_q, cmd_d;
  logic [2:0]            dummy_cnt_q, dummy_cnt_d;
`endif

  logic                  cs_rise, cs_fall, clk_rise, clk_fall;
  logic [ADDR_WIDTH-1:0] rx_in;
  logic [7:0]            id_byte, load_byte;

  assign cs_rise  = ~cs_prev_q & cs_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_sync_q[1];
  assign clk_rise = ~clk_prev_q & clk_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_sync_q[1];
  assign rx_in    = {rx_sr_q, mosi_sync_q[1]};

  always_comb begin
    id_byte = 8'hFF;
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
  end

  always_comb begin
    cs_sync_d    = {cs_sync_q[0], spiflash_cs_n};
    clk_sync_d   = {clk_sync_q[0], spiflash_clk};
    mosi_sync_d  = {mosi_sync_q[0], spiflash_mosi};
    cs_prev_d    = cs_sync_q[1];
    clk_prev_d   = clk_sync_q[1];
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_en_d     = 1'b0;
    // Memory data arrives the cycle after the strobe.
    fetch_pend_d = mem_en_q;
    prefetch_d   = fetch_pend_q ? mem_rdata : prefetch_q;
    tx_sr_d      = tx_sr_q;
    tx_cnt_d     = tx_cnt_q;
    id_idx_d     = id_idx_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    load_byte    = 8'h00;
`ifdef SPIFLASH_RESP_FASTREAD_EN
    cmd_d        = cmd_q;
    dummy_cnt_d  = dummy_cnt_q;
`endif

    if (cs_rise) begin
      state_d      = S_IDLE;
      miso_d       = 1'b0;
      miso_oe_d    = 1'b0;
      fetch_pend_d = 1'b0;
      prefetch_d   = prefetch_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 5'd0;
          end
        end
        S_CMD: begin
          if (clk_rise) begin
            rx_sr_d   = rx_in[SR_W-1:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              tx_cnt_d  = 3'd0;
              id_idx_d  = 2'd0;
`ifdef SPIFLASH_RESP_FASTREAD_EN
              cmd_d     = rx_in[7:0];
`endif
              case (rx_in[7:0])
                8'h03:   state_d = S_ADDR;
`ifdef SPIFLASH_RESP_FASTREAD_EN
                8'h0B:   state_d = S_ADDR;
`endif
                8'h9F:   state_d = S_ID;
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (clk_rise) begin
            rx_sr_d   = rx_in[SR_W-1:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              // Fetch the first byte now so it is buffered before the next SPI fall.
              bit_cnt_d  = 5'd0;
              addr_d     = rx_in;
              mem_addr_d = rx_in;
              mem_en_d   = 1'b1;
              tx_cnt_d   = 3'd0;
              state_d    = S_DATA;
`ifdef SPIFLASH_RESP_FASTREAD_EN
              if (cmd_q == 8'h0B) begin
                state_d     = S_DUMMY;
                dummy_cnt_d = 3'd0;
              end
`endif
            end
          end
        end
`ifdef SPIFLASH_RESP_FASTREAD_EN
        S_DUMMY: begin
          if (clk_rise) begin
            dummy_cnt_d = dummy_cnt_q + 3'd1;
            if (dummy_cnt_q == 3'd7) state_d = S_DATA;
          end
        end
`endif
        S_DATA, S_ID: begin
          if (clk_fall) begin
            miso_oe_d = 1'b1;
            tx_cnt_d  = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd0) begin
              // Byte boundary: take the buffered byte and refill the buffer behind it.
              load_byte = (state_q == S_DATA) ? prefetch_q : id_byte;
              miso_d    = load_byte[7];
              tx_sr_d   = {load_byte[6:0], 1'b0};
              if (state_q == S_DATA) begin
                addr_d     = addr_q + ADDR_WIDTH'(1);
                mem_addr_d = addr_q + ADDR_WIDTH'(1);
                mem_en_d   = 1'b1;
              end else if (id_idx_q != 2'd3) begin
                id_idx_d = id_idx_q + 2'd1;
              end
            end else begin
              miso_d  = tx_sr_q[7];
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cs_sync_q    <= 2'b00;
      clk_sync_q   <= 2'b00;
      mosi_sync_q  <= 2'b00;
      cs_prev_q    <= 1'b0;
      clk_prev_q   <= 1'b0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 5'd0;
      rx_sr_q      <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_en_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      prefetch_q   <= 8'h00;
      tx_sr_q      <= 8'h00;
      tx_cnt_q     <= 3'd0;
      id_idx_q     <= 2'd0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
`ifdef SPIFLASH_RESP_FASTREAD_EN
      cmd_q        <= 8'h00;
      dummy_cnt_q  <= 3'd0;
`endif
    end else begin
      cs_sync_q    <= cs_sync_d;
      clk_sync_q   <= clk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_prev_q    <= cs_prev_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_q     <= mem_en_d;
      fetch_pend_q <= fetch_pend_d;
      prefetch_q   <= prefetch_d;
      tx_sr_q      <= tx_sr_d;
      tx_cnt_q     <= tx_cnt_d;
      id_idx_q     <= id_idx_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
`ifdef SPIFLASH_RESP_FASTREAD_EN
      cmd_q        <= cmd_d;
      dummy_cnt_q  <= dummy_cnt_d;
`endif
    end
  end

  assign spiflash_miso    = miso_q;
  assign spiflash_miso_oe = miso_oe_q;
  assign mem_en           = mem_en_q;
  assign mem_addr         = mem_addr_q;

endmodule

// File: doc/spiflash_responder.md
# spiflash_responder

Synthesizable SPI flash target that answers the management SoC's flash controller (`spiflash_cs_n`/`spiflash_clk`/`spiflash_mosi`/`spiflash_miso`) from an on-chip synchronous-read memory port. It oversamples the SPI pins in the `core_clk` domain, decodes READ and JEDEC-ID commands, and streams bytes MSB-first in SPI mode 0. It replaces the behavioural flash model in FPGA builds and in gate-level benches.

## Interface
- `ADDR_WIDTH`, 12: memory address width; the low `ADDR_WIDTH` bits of the 24-bit SPI address are used.
- `JEDEC_ID`, 24'hEF4016: 3-byte ID returned for command 0x9F, MSB byte first.
- `core_clk` input 1: block clock. All logic is on its rising edge.
- `core_rst_n` input 1: asynchronous, active-low reset.
- `spiflash_cs_n` input 1: chip select from the SoC (asynchronous to `core_clk`).
- `spiflash_clk` input 1: SPI clock from the SoC (asynchronous to `core_clk`).
- `spiflash_mosi` input 1: command, address and dummy bits.
- `spiflash_miso` output 1: data bits; 0 whenever `spiflash_miso_oe`=0.
- `spiflash_miso_oe` output 1: drive enable for the pad.
- `mem_en` output 1: one-cycle read strobe.
- `mem_addr` output ADDR_WIDTH: read address, valid while `mem_en`=1.
- `mem_rdata` input 8: read data, valid exactly 1 cycle after `mem_en`.

## Operation
- `cs_n`, `clk` and `mosi` each pass through a 2-FF synchronizer. Edges are detected from the synchronized values.
- States: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- A synchronized `cs_n` fall moves IDLE→CMD and clears the bit counter. A `cs_n` rise in any state moves to IDLE, clears `miso_oe` and drops any pending fetch. There is no partial-transfer memory.
- MOSI is sampled on each synchronized `clk` rise and shifted in MSB-first.
- CMD: after 8 bits, the command is decoded:
  - 0x03 → ADDR.
  - 0x0B → ADDR (only with the FASTREAD macro; otherwise IGNORE).
  - 0x9F → ID.
  - Anything else → IGNORE.
- ADDR: collects 24 bits.
  - On the rise of bit 24, the block issues `mem_en` with `mem_addr`=addr[ADDR_WIDTH-1:0] and latches `mem_rdata` into the prefetch buffer the next cycle.
  - Then: 0x03 → DATA; 0x0B → DUMMY.
- DUMMY: ignores 8 clock rises, then goes to DATA. MISO stays undriven (`miso_oe`=0) throughout.
- DATA:
  - On each `clk` fall, the block drives the next bit and sets `miso_oe`=1.
  - At a byte boundary, the prefetch buffer loads into the TX shift register, and on the same cycle `mem_en` issues for addr+1.
  - The address increments modulo 2^ADDR_WIDTH, so it wraps from all-ones to 0.
  - Streaming continues until `cs_n` rises.
- ID: streams the 3 `JEDEC_ID` bytes, then 0xFF until `cs_n` rises. No memory access occurs.
- IGNORE: no output and no memory access until `cs_n` rises.
- If the SoC holds `cs_n` high with no clocks, nothing happens. If clock edges arrive while `cs_n` is high, they are ignored.
- Reset values: `spiflash_miso`=0, `spiflash_miso_oe`=0, `mem_en`=0, `mem_addr`=0, state=IDLE, all counters and shifters 0.
- Asserting reset mid-transfer returns the block to IDLE immediately. The next transfer requires a fresh `cs_n` fall.

## Timing
- `spiflash_clk` high and low phases must each be ≥8 `core_clk` cycles. `cs_n` setup and hold relative to the first and last clock edge must each be ≥8 cycles.
- Pin to internal edge detect takes 3 `core_clk` cycles.
- Fetch: `mem_en` is high in cycle N and data is captured in N+1. The prefetch buffer is valid ≤5 cycles after the sampling `clk` rise, which is before the next `clk` fall.
- MISO changes 3–4 cycles after the SPI falling edge and is stable at the following rising edge.
- `miso_oe` clears ≤4 cycles after the `cs_n` rise.
- `mem_en` is never high for 2 consecutive cycles.

## Configuration
- `SPIFLASH_RESP_FASTREAD_EN`:
  - Defined: command 0x0B (FAST READ with 8 dummy clocks) is supported, and the DUMMY state exists.
  - Undefined: 0x0B goes to IGNORE, and the DUMMY state and its counter are not synthesized.

## Test plan
- Memory byte i = i[7:0]. Send 0x03, address 0x000010, then 32 clocks → MISO bytes 0x10, 0x11, 0x12, 0x13; four `mem_en` pulses plus one prefetch for 0x014.
- ADDR_WIDTH=12. Send 0x03, address 0x000FFE, then 3 bytes → 0xFE, 0xFF, 0x00, with `mem_addr` wrapping to 0x000.
- Send 0x9F, then 32 clocks → 0xEF, 0x40, 0x16, 0xFF; `mem_en` is never asserted.
- Send 0x0B, address 0x000020, 8 dummy clocks, 1 byte → with the macro defined, `miso_oe`=0 during dummy and the byte is 0x20; without the macro, `miso_oe` stays 0 throughout.
- Raise `cs_n` after 4 data bits of a 0x03 read → `miso_oe`=0 within 4 cycles; the next 0x03 at 0x000005 returns 0x05.
- Send command 0x5A with 24 clocks → no `mem_en` and `miso_oe`=0. Then assert `core_rst_n`=0 mid-byte of a read → all outputs are 0 immediately and the next transaction is correct.
